// File: rtl/grf_wb_writer_pkg.sv
// Shared types and constants for the GRF writeback writer.
//   REG_ADDR_W / DATA_W : register-address and data widths
//   ZERO_REG            : hard-wired zero register, never written or forwarded
//   wb_req_t            : one queued register write {addr, data, pc}
package grf_wb_writer_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
    logic [DATA_W-1:0]     pc;
  } wb_req_t;

endpackage

// File: rtl/grf_wb_writer_if.sv
// Writeback-stage request channel (valid/ready handshake).
//   master : writeback stage, drives the request and samples in_ready
//   slave  : grf_wb_writer, samples the request and drives in_ready
interface grf_wb_writer_if;
  import grf_wb_writer_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_wren;
  logic [REG_ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0]     in_data;
  logic [DATA_W-1:0]     in_pc;

  modport master (output in_valid, in_wren, in_addr, in_data, in_pc, input in_ready);
  modport slave  (input in_valid, in_wren, in_addr, in_data, in_pc, output in_ready);

endinterface

// File: rtl/grf_wb_fifo.sv
// In-order storage for pending register writes.
//   clk, reset : clock, async active-low reset (clears pointers and count)
//   push       : enqueue push_req at tail
//   pop        : dequeue head entry (caller guarantees count != 0)
//   entries    : raw storage array, for the parent's forwarding search
//   valid      : per-slot occupancy bit
//   head       : index of the oldest entry
//   count      : current occupancy
module grf_wb_fifo
  import grf_wb_writer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_req_t          push_req,
  input  logic             pop,
  output wb_req_t          entries [DEPTH],
  output logic [DEPTH-1:0] valid,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W:0]   count
);

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] offset;

  // Pointer and occupancy state; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_req;
  end

  assign entries = mem;

  // A slot is occupied when its distance from head is below count.
  always_comb begin
    valid  = '0;
    offset = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      offset   = PTR_W'(i) - head;
      valid[i] = ({1'b0, offset} < count);
    end
  end

endmodule

// File: rtl/grf_wb_writer.sv
// Writeback-side initiator for the GRF write port.
//   clk, reset     : clock, async active-low reset
//   req            : writeback request channel (slave side)
//   wb_hold        : GRF write port busy, suppress drain this cycle
//   A3/WD/WrEn/PC  : registered GRF write port
//   q_addr         : forwarding query address
//   q_hit/q_data   : youngest pending write to q_addr (combinational)
//   count          : FIFO occupancy
module grf_wb_writer
  import grf_wb_writer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  grf_wb_writer_if.slave        req,
  input  logic                  wb_hold,
  output logic [REG_ADDR_W-1:0] A3,
  output logic [DATA_W-1:0]     WD,
  output logic                  WrEn,
  output logic [DATA_W-1:0]     PC,
  input  logic [REG_ADDR_W-1:0] q_addr,
  output logic                  q_hit,
  output logic [DATA_W-1:0]     q_data,
  output logic [PTR_W:0]        count
);

  wb_req_t          entries [DEPTH];
  wb_req_t          push_req;
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] idx;
  logic             push;
  logic             pop;

  // Ready is a pure function of occupancy; no bypass when a pop is pending.
  assign req.in_ready = (count != (PTR_W+1)'(DEPTH));

  // Non-writing and r0 transfers are accepted but never queued.
  assign push = req.in_valid && req.in_ready && req.in_wren && (req.in_addr != ZERO_REG);
  assign pop  = (count != '0) && !wb_hold;

  assign push_req = '{addr: req.in_addr, data: req.in_data, pc: req.in_pc};

  grf_wb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .entries  (entries),
    .valid    (valid),
    .head     (head),
    .count    (count)
  );

  // Commit stage: one WrEn pulse per popped entry; address/data/pc hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      A3   <= '0;
      WD   <= '0;
      PC   <= '0;
      WrEn <= 1'b0;
    end else if (pop) begin
      A3   <= entries[head].addr;
      WD   <= entries[head].data;
      PC   <= entries[head].pc;
      WrEn <= 1'b1;
    end else begin
      WrEn <= 1'b0;
    end
  end

  // Forwarding: commit stage first, then FIFO oldest-to-youngest so the youngest match wins.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    idx    = '0;
    if (q_addr != ZERO_REG) begin
      if (WrEn && (A3 == q_addr)) begin
        q_hit  = 1'b1;
        q_data = WD;
      end
      for (int k = 0; k < int'(DEPTH); k++) begin
        idx = head + PTR_W'(k);
        if (valid[idx] && (entries[idx].addr == q_addr)) begin
          q_hit  = 1'b1;
          q_data = entries[idx].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_grf_wb_writer.sv
// Directed bench for grf_wb_writer: single write, dropped requests, full/stall,
// forwarding priority, streaming with wrap, and asynchronous reset mid-drain.
module tb_grf_wb_writer;
  import grf_wb_writer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic                  clk;
  logic                  reset;
  logic                  wb_hold;
  logic [REG_ADDR_W-1:0] A3;
  logic [DATA_W-1:0]     WD;
  logic                  WrEn;
  logic [DATA_W-1:0]     PC;
  logic [REG_ADDR_W-1:0] q_addr;
  logic                  q_hit;
  logic [DATA_W-1:0]     q_data;
  logic [PTR_W:0]        count;

  int checks   = 0;
  int failures = 0;

  grf_wb_writer_if wb_if ();

  grf_wb_writer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (wb_if.slave),
    .wb_hold (wb_hold),
    .A3      (A3),
    .WD      (WD),
    .WrEn    (WrEn),
    .PC      (PC),
    .q_addr  (q_addr),
    .q_hit   (q_hit),
    .q_data  (q_data),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic [31:0] p);
    wb_if.in_valid = v;
    wb_if.in_wren  = w;
    wb_if.in_addr  = a;
    wb_if.in_data  = d;
    wb_if.in_pc    = p;
  endtask

  wb_req_t exp_q [$];
  wb_req_t front;
  int      sent;
  int      got;
  int      cyc;
  logic    exp_pop;
  logic    accept;

  initial begin
    reset   = 1'b0;
    wb_hold = 1'b0;
    q_addr  = '0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #2;
    check("rst_wren", WrEn, 0);
    check("rst_count", count, 0);
    check("rst_a3", A3, 0);
    check("rst_wd", WD, 0);
    check("rst_pc", PC, 0);
    check("rst_ready", wb_if.in_ready, 1);
    @(negedge clk);
    reset = 1'b1;

    // Single request: WrEn one cycle after accept, for exactly one cycle.
    drive(1'b1, 1'b1, 5'd5, 32'h1234, 32'h3000);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    check("t1_count_after_accept", count, 1);
    check("t1_wren_early", WrEn, 0);
    tick();
    check("t1_wren", WrEn, 1);
    check("t1_a3", A3, 5);
    check("t1_wd", WD, 32'h1234);
    check("t1_pc", PC, 32'h3000);
    check("t1_count_drained", count, 0);
    tick();
    check("t1_wren_drop", WrEn, 0);
    check("t1_a3_hold", A3, 5);

    // r0 and non-writing requests are consumed but dropped.
    drive(1'b1, 1'b1, 5'd0, 32'hDEAD, 32'h10);
    check("t2_ready_r0", wb_if.in_ready, 1);
    tick();
    check("t2_count_r0", count, 0);
    drive(1'b1, 1'b0, 5'd7, 32'hBEEF, 32'h14);
    check("t2_ready_nowren", wb_if.in_ready, 1);
    tick();
    check("t2_count_nowren", count, 0);
    check("t2_wren_a", WrEn, 0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    check("t2_wren_b", WrEn, 0);

    // Fill under hold, stall the fifth, then drain in order.
    wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b1, 5'(i), 32'hA0 + 32'(i), 32'h100 + 32'(4 * i));
      tick();
    end
    check("t3_count_full", count, 4);
    check("t3_ready_full", wb_if.in_ready, 0);
    drive(1'b1, 1'b1, 5'd9, 32'hB5, 32'h200);
    tick();
    check("t3_count_stall", count, 4);
    check("t3_wren_hold", WrEn, 0);
    wb_hold = 1'b0;
    tick();
    check("t3_p1_wren", WrEn, 1);
    check("t3_p1_a3", A3, 1);
    check("t3_p1_wd", WD, 32'hA1);
    check("t3_p1_count", count, 3);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    check("t3_p2_a3", A3, 2);
    check("t3_p2_pc", PC, 32'h108);
    check("t3_p2_count", count, 3);
    tick();
    check("t3_p3_a3", A3, 3);
    check("t3_p3_wren", WrEn, 1);
    tick();
    check("t3_p4_a3", A3, 4);
    check("t3_p4_wd", WD, 32'hA4);
    tick();
    check("t3_p5_wren", WrEn, 1);
    check("t3_p5_a3", A3, 9);
    check("t3_p5_wd", WD, 32'hB5);
    check("t3_p5_pc", PC, 32'h200);
    check("t3_p5_count", count, 0);
    tick();
    check("t3_end_wren", WrEn, 0);

    // Forwarding: youngest wins, commit stage has lowest priority.
    wb_hold = 1'b1;
    drive(1'b1, 1'b1, 5'd8, 32'h11, 32'h500);
    tick();
    drive(1'b1, 1'b1, 5'd8, 32'h22, 32'h504);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    q_addr = 5'd8;
    #1;
    check("t4_hit_q", q_hit, 1);
    check("t4_data_q", q_data, 32'h22);
    q_addr = 5'd0;
    #1;
    check("t4_hit_r0", q_hit, 0);
    check("t4_data_r0", q_data, 0);
    q_addr = 5'd3;
    #1;
    check("t4_hit_miss", q_hit, 0);
    check("t4_data_miss", q_data, 0);
    q_addr = 5'd8;
    wb_hold = 1'b0;
    tick();
    check("t4_d1_wd", WD, 32'h11);
    check("t4_d1_data", q_data, 32'h22);
    tick();
    check("t4_d2_wd", WD, 32'h22);
    check("t4_d2_hit", q_hit, 1);
    check("t4_d2_data", q_data, 32'h22);
    q_addr = 5'd0;
    #1;
    check("t4_d2_hit_r0", q_hit, 0);
    q_addr = 5'd8;
    tick();
    check("t4_d3_hit", q_hit, 0);
    check("t4_d3_data", q_data, 0);

    // Streaming 3*DEPTH requests with alternating hold, scoreboarded in order.
    sent = 0;
    got  = 0;
    cyc  = 0;
    while ((sent < 3 * int'(DEPTH) || exp_q.size() != 0) && cyc < 200) begin
      wb_hold = cyc[0];
      if (sent < 3 * int'(DEPTH))
        drive(1'b1, 1'b1, 5'((sent % 31) + 1), 32'hC000 + 32'(sent), 32'h4000 + 32'(4 * sent));
      else
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      #1;
      check("t5_ready", wb_if.in_ready, (exp_q.size() != int'(DEPTH)));
      exp_pop = (exp_q.size() != 0) && !wb_hold;
      accept  = wb_if.in_valid && (exp_q.size() != int'(DEPTH));
      tick();
      check("t5_wren", WrEn, exp_pop);
      if (exp_pop) begin
        front = exp_q.pop_front();
        check("t5_a3", A3, front.addr);
        check("t5_wd", WD, front.data);
        check("t5_pc", PC, front.pc);
        got++;
      end
      if (accept) begin
        exp_q.push_back('{addr: wb_if.in_addr, data: wb_if.in_data, pc: wb_if.in_pc});
        sent++;
      end
      check("t5_count", count, exp_q.size());
      check("t5_count_le_depth", (count <= (PTR_W+1)'(DEPTH)), 1);
      cyc++;
    end
    check("t5_all_drained", got, 3 * DEPTH);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();

    // Asynchronous reset mid-drain discards everything.
    wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'(10 + i), 32'hE0 + 32'(i), 32'h600 + 32'(4 * i));
      tick();
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    wb_hold = 1'b0;
    tick();
    check("t6_pre_wren", WrEn, 1);
    check("t6_pre_count", count, 2);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_wren", WrEn, 0);
    check("t6_async_count", count, 0);
    check("t6_async_a3", A3, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t6_post_wren", WrEn, 0);
      check("t6_post_count", count, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grf_wb_writer.md
Name: grf_wb_writer

Overview:
- Writeback-side initiator for the general register file (GRF) write port.
- Accepts register-write requests from the writeback stage through a valid/ready handshake and buffers them in an in-order FIFO.
- Drains one request per cycle onto the GRF write port (A3/WD/WrEn/PC).
- Provides a pending-write lookup so decode can forward values not yet committed to the GRF.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), width of the FIFO pointers.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request this cycle.
- in_wren  input  1  request actually writes a register.
- in_addr  input  5  destination register.
- in_data  input  32  write data.
- in_pc  input  32  PC of the producing instruction, carried for the write log.
- wb_hold  input  1  GRF write port unavailable; no drain this cycle.
- A3  output  5  GRF write address (registered).
- WD  output  32  GRF write data (registered).
- WrEn  output  1  GRF write enable (registered).
- PC  output  32  PC accompanying the write (registered).
- q_addr  input  5  forwarding query address.
- q_hit  output  1  a pending write to q_addr exists.
- q_data  output  32  value of the youngest pending write to q_addr.
- count  output  PTR_W+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - count, head and tail pointers go to 0.
  - A3, WD, PC go to 0; WrEn goes to 0.
  - FIFO contents are don't-care.
  - Reset mid-operation discards all queued and commit-stage writes; nothing reaches the GRF.
- Accept:
  - in_ready = (count != DEPTH). in_ready depends only on state, never on in_valid.
  - A transfer happens on a rising edge with in_valid && in_ready.
  - Transfers with in_wren=0 or in_addr=0 are consumed and dropped; they are not enqueued.
- Drain:
  - Pop happens when count != 0 && !wb_hold.
  - On a pop edge the commit registers load {A3, WD, PC} from the head entry and WrEn <= 1.
  - Otherwise WrEn <= 0. A3, WD and PC hold their previous values.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Full plus pop: in_ready is still 0 that cycle. There is no combinational bypass.
- Empty: no pop. An incoming request is never passed straight through.
- Pointers wrap modulo DEPTH.
- Latency: a request accepted at edge N is popped no earlier than edge N+1. WrEn is then high during cycle N+1, and the GRF writes at edge N+2. Minimum latency is 2 cycles from accept to register update.
- Ordering: strictly in order; each accepted request produces exactly one WrEn pulse.
- Forwarding (purely combinational from state and q_addr):
  - Candidates are all valid FIFO entries plus the commit stage when WrEn=1.
  - The youngest match wins. Priority runs from the tail-1 entry down to the head entry; the commit stage has the lowest priority.
  - q_addr=0 gives q_hit=0 and q_data=0.
  - No match gives q_hit=0 and q_data=0.
  - Same-cycle in_* requests are not visible to the query.
- Under wb_hold=1 with WrEn already 1: WrEn drops to 0 at the next edge. The pulse is never repeated.

Decomposition:
- Shared package:
  - REG_ADDR_W=5, DATA_W=32.
  - wb_req_t struct {addr, data, pc}.
  - ZERO_REG=5'd0.
- One sub-module: grf_wb_fifo, the storage array with pointers and count, exposing all entries and valid bits to the parent's match logic.
- The forwarding priority search stays in the parent.

Test Plan:
- Reset then a single request {addr=5, data=0x1234, pc=0x3000} with wb_hold=0 -> WrEn=1, A3=5, WD=0x1234, PC=0x3000 exactly 1 cycle after accept; WrEn=0 the following cycle.
- Requests with addr=0 and with in_wren=0 -> in_ready stays 1, count stays 0, WrEn never asserts.
- wb_hold=1, push 4 requests -> count=4, in_ready=0; 5th request stalls. Release hold -> 4 consecutive WrEn pulses in order, then the 5th is accepted and drained.
- Push {r8=0x11} then {r8=0x22} under hold, q_addr=8 -> q_hit=1, q_data=0x22. Drain both -> q_data=0x22 while the second is in the commit stage, q_hit=0 afterwards. q_addr=0 -> q_hit=0 throughout.
- Continuous push and pop for 3*DEPTH requests with alternating wb_hold -> count stays ≤ DEPTH, pointers wrap, output sequence equals input sequence.
- Assert reset low mid-drain with 3 entries queued -> WrEn=0 and count=0 immediately (no clock edge needed); no further writes after reset releases.
